// File: rtl/hazard_unit.sv
// Hazard detection, stall/flush sequencing and forwarding selects for the five-stage core.
// Sequential state: divider countdown and an exception redirect deferred behind cache stalls.
//
// state | meaning
// RUN   | normal operation, no redirect owed
// PEND  | exception seen while frozen; redirect due on first unfrozen cycle
module hazard_unit #(
  parameter int DIV_CYCLES = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  WriteReg_E,
  input  logic [4:0]  WriteReg_M,
  input  logic [4:0]  WriteReg_W,
  input  logic        RegWrite_E,
  input  logic        RegWrite_M,
  input  logic        RegWrite_W,
  input  logic [2:0]  MemtoReg_E,
  input  logic [2:0]  MemtoReg_M,
  input  logic        Branch1_D,
  input  logic        Branch2_D,
  input  logic        JumpJr_D,
  input  logic        div_start_E,
  input  logic        inst_stall_F,
  input  logic        data_stall_M,
  input  logic [31:0] except_type_M,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Stall_W,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Flush_M,
  output logic        Flush_W,
  output logic        ForwardA_D,
  output logic        ForwardB_D,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        exc_redirect,
  output logic        div_busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic freeze, exc, redirect_now, flush_all;
  logic use_rs, use_rt, lwstall, brstall, div_stall;

  // Register zero is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (RegWrite_M && reg_match(WriteReg_M, src))
      return 2'b10;
    else if (RegWrite_W && reg_match(WriteReg_W, src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic br_dep(input logic [4:0] op);
    return (RegWrite_E && reg_match(WriteReg_E, op)) ||
           ((MemtoReg_M != 3'd0) && reg_match(WriteReg_M, op));
  endfunction

  assign freeze       = inst_stall_F | data_stall_M;
  assign exc          = except_type_M != 32'd0;
  assign redirect_now = ~freeze & (exc | (state_q == ST_PEND));
  assign flush_all    = rst | redirect_now;

  assign use_rs = Branch1_D | Branch2_D | JumpJr_D;
  assign use_rt = Branch1_D;

  assign lwstall = RegWrite_E & (MemtoReg_E != 3'd0) &
                   (reg_match(WriteReg_E, rs_D) | reg_match(WriteReg_E, rt_D));
  assign brstall = (use_rs & br_dep(rs_D)) | (use_rt & br_dep(rt_D));

  // A divide is released on the single cycle its count sits at one.
  assign div_stall = div_start_E & (cnt_q != CNT_ONE);
  assign div_busy  = cnt_q != '0;

  assign ForwardA_E = fwd_sel(rs_E);
  assign ForwardB_E = fwd_sel(rt_E);
  assign ForwardA_D = RegWrite_M & reg_match(WriteReg_M, rs_D);
  assign ForwardB_D = RegWrite_M & reg_match(WriteReg_M, rt_D);

  always_comb begin
    Stall_F      = 1'b0;
    Stall_D      = 1'b0;
    Stall_E      = 1'b0;
    Stall_M      = 1'b0;
    Stall_W      = 1'b0;
    Flush_D      = 1'b0;
    Flush_E      = 1'b0;
    Flush_M      = 1'b0;
    Flush_W      = 1'b0;
    exc_redirect = 1'b0;
    state_d      = state_q;
    if (rst) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
      Flush_M = 1'b1;
      Flush_W = 1'b1;
      state_d = ST_RUN;
    end else if (freeze) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Stall_W = 1'b1;
      if (exc) state_d = ST_PEND;
    end else if (redirect_now) begin
      Flush_D      = 1'b1;
      Flush_E      = 1'b1;
      Flush_M      = 1'b1;
      Flush_W      = 1'b1;
      exc_redirect = 1'b1;
      state_d      = ST_RUN;
    end else if (div_stall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Flush_M = 1'b1;
    end else if (lwstall | brstall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  // Holding at one while frozen keeps the divide from completing under a stalled pipe.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_all)
      cnt_d = '0;
    else if (cnt_q == '0) begin
      if (div_start_E) cnt_d = CNT_LOAD;
    end else if (cnt_q != CNT_ONE)
      cnt_d = cnt_q - CNT_ONE;
    else if (!freeze)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model of the hazard rules.
module tb_hazard_unit;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E;
  logic [4:0]  WriteReg_E, WriteReg_M, WriteReg_W;
  logic        RegWrite_E, RegWrite_M, RegWrite_W;
  logic [2:0]  MemtoReg_E, MemtoReg_M;
  logic        Branch1_D, Branch2_D, JumpJr_D;
  logic        div_start_E, inst_stall_F, data_stall_M;
  logic [31:0] except_type_M;
  logic        Stall_F, Stall_D, Stall_E, Stall_M, Stall_W;
  logic        Flush_D, Flush_E, Flush_M, Flush_W;
  logic        ForwardA_D, ForwardB_D;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        exc_redirect, div_busy;

  int checks = 0;
  int failures = 0;

  hazard_unit #(.DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
    .Branch1_D(Branch1_D), .Branch2_D(Branch2_D), .JumpJr_D(JumpJr_D),
    .div_start_E(div_start_E), .inst_stall_F(inst_stall_F), .data_stall_M(data_stall_M),
    .except_type_M(except_type_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M), .Stall_W(Stall_W),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .exc_redirect(exc_redirect), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_el counts divide cycles already spent in EX after the start cycle (0 = idle).
  int m_el = 0, m_el_n = 0;
  bit m_pend = 0, m_pend_n = 0;
  bit m_ok = 0;

  function automatic bit nz_eq(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
    if (RegWrite_M && nz_eq(WriteReg_M, src)) return 2'b10;
    if (RegWrite_W && nz_eq(WriteReg_W, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_br_dep(input logic [4:0] op);
    return (RegWrite_E && nz_eq(WriteReg_E, op)) || (MemtoReg_M != 0 && nz_eq(WriteReg_M, op));
  endfunction

  function automatic int m_div_next(input int el, input bit start, input bit frz);
    if (el == 0) return start ? 1 : 0;
    if (el < DC) return el + 1;
    return frz ? DC : 0;
  endfunction

  always @(negedge clk) begin
    bit frz, ex, lw, br, dv;
    logic [4:0] e_st;
    logic [3:0] e_fl;
    bit e_red;
    frz = inst_stall_F || data_stall_M;
    ex  = except_type_M != 0;
    lw  = RegWrite_E && MemtoReg_E != 0 && (nz_eq(WriteReg_E, rs_D) || nz_eq(WriteReg_E, rt_D));
    br  = ((Branch1_D || Branch2_D || JumpJr_D) && m_br_dep(rs_D)) || (Branch1_D && m_br_dep(rt_D));
    dv  = div_start_E && (m_el != DC);
    e_st = 5'b0; e_fl = 4'b0; e_red = 0;
    if (rst) e_fl = 4'hF;
    else if (frz) e_st = 5'h1F;
    else if (ex || m_pend) begin e_fl = 4'hF; e_red = 1; end
    else if (dv) begin e_st = 5'b11100; e_fl = 4'b0010; end
    else if (lw || br) begin e_st = 5'b11000; e_fl = 4'b0100; end

    if (rst) begin m_pend_n = 0; m_el_n = 0; end
    else if (frz) begin m_pend_n = m_pend || ex; m_el_n = m_div_next(m_el, div_start_E, 1'b1); end
    else if (ex || m_pend) begin m_pend_n = 0; m_el_n = 0; end
    else begin m_pend_n = 0; m_el_n = m_div_next(m_el, div_start_E, 1'b0); end

    if (m_ok) begin
      chk("model_stalls", {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W}, e_st);
      chk("model_flushes", {Flush_D, Flush_E, Flush_M, Flush_W}, e_fl);
      chk("model_redirect", exc_redirect, e_red);
      chk("model_div_busy", div_busy, m_el != 0);
      chk("model_fwd_e", {ForwardA_E, ForwardB_E}, {m_fwd_e(rs_E), m_fwd_e(rt_E)});
      chk("model_fwd_d", {ForwardA_D, ForwardB_D},
          {RegWrite_M && nz_eq(WriteReg_M, rs_D), RegWrite_M && nz_eq(WriteReg_M, rt_D)});
    end
  end

  always @(posedge clk) begin
    m_pend = m_pend_n;
    m_el   = m_el_n;
    if (rst) m_ok = 1;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rst = 0;
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
    WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    MemtoReg_E = 0; MemtoReg_M = 0;
    Branch1_D = 0; Branch2_D = 0; JumpJr_D = 0;
    div_start_E = 0; inst_stall_F = 0; data_stall_M = 0;
    except_type_M = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  int exp_se[13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_bz[13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    idle();
    rst = 1;
    advance();
    settle();
    chk("reset_flush_d", Flush_D, 1);
    chk("reset_flush_w", Flush_W, 1);
    chk("reset_stall_f", Stall_F, 0);
    chk("reset_div_busy", div_busy, 0);
    advance();
    idle();

    // forwarding
    RegWrite_M = 1; WriteReg_M = 5; RegWrite_W = 1; WriteReg_W = 5; rs_E = 5;
    settle(); chk("fwd_mem_wins", ForwardA_E, 2'b10);
    advance(); RegWrite_M = 0;
    settle(); chk("fwd_wb", ForwardA_E, 2'b01);
    advance(); rs_E = 0;
    settle(); chk("fwd_r0", ForwardA_E, 2'b00);
    advance(); idle();

    // load-use
    MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 8; rt_D = 8;
    settle();
    chk("lw_stall_fd", {Stall_F, Stall_D, Flush_E}, 3'b111);
    chk("lw_stall_e", Stall_E, 0);
    advance(); WriteReg_E = 0;
    settle(); chk("lw_r0", {Stall_F, Stall_D, Flush_E}, 3'b000);
    advance(); idle();

    // branch operand hazard
    Branch2_D = 1; rs_D = 3; MemtoReg_M = 1; WriteReg_M = 3;
    settle(); chk("br_load_stall", {Stall_F, Stall_D, Flush_E}, 3'b111);
    advance(); MemtoReg_M = 0; RegWrite_M = 1;
    settle();
    chk("br_fwd_nostall", Stall_F, 0);
    chk("br_fwd_d", ForwardA_D, 1);
    advance(); idle();

    // divide: full count, back-to-back restart, freeze while count is at one
    for (int k = 0; k < 13; k++) begin
      div_start_E  = (k < 12);
      inst_stall_F = (k == 9 || k == 10);
      settle();
      chk($sformatf("div_stall_e_%0d", k), Stall_E, exp_se[k]);
      chk($sformatf("div_busy_%0d", k), div_busy, exp_bz[k]);
      advance();
    end
    idle();

    // exception deferred behind a data stall
    for (int k = 0; k < 3; k++) begin
      data_stall_M = 1; except_type_M = 32'h10;
      settle();
      chk("exc_frozen_stall", {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W}, 5'h1F);
      chk("exc_frozen_noredir", exc_redirect, 0);
      advance();
    end
    idle();
    settle();
    chk("exc_deferred_redir", exc_redirect, 1);
    chk("exc_deferred_flush", {Flush_D, Flush_E, Flush_M, Flush_W}, 4'hF);
    advance();
    settle();
    chk("exc_single_pulse", exc_redirect, 0);
    chk("exc_back_to_run", Flush_D, 0);
    advance();

    // reset during a divide while a redirect is pending
    div_start_E = 1;
    advance();
    data_stall_M = 1; except_type_M = 32'h10;
    advance();
    rst = 1;
    settle();
    chk("rst_pend_flush", Flush_D, 1);
    chk("rst_pend_noredir", exc_redirect, 0);
    advance();
    settle();
    chk("rst_pend_busy", div_busy, 0);
    advance();
    idle();
    settle();
    chk("rst_pend_cleared", exc_redirect, 0);
    chk("rst_pend_idle", div_busy, 0);
    advance();

    // random stimulus, checked by the model process
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      inst_stall_F = ($urandom_range(0, 9) == 0);
      data_stall_M = ($urandom_range(0, 9) == 0);
      except_type_M = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1, 1000)) : 32'd0;
      if ($urandom_range(0, 7) == 0) div_start_E = ~div_start_E;
      rs_D = 5'($urandom_range(0, 7)); rt_D = 5'($urandom_range(0, 7));
      rs_E = 5'($urandom_range(0, 7)); rt_E = 5'($urandom_range(0, 7));
      WriteReg_E = 5'($urandom_range(0, 7));
      WriteReg_M = 5'($urandom_range(0, 7));
      WriteReg_W = 5'($urandom_range(0, 7));
      RegWrite_E = 1'($urandom_range(0, 1));
      RegWrite_M = 1'($urandom_range(0, 1));
      RegWrite_W = 1'($urandom_range(0, 1));
      MemtoReg_E = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      MemtoReg_M = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      Branch1_D = ($urandom_range(0, 3) == 0);
      Branch2_D = ($urandom_range(0, 3) == 0);
      JumpJr_D  = ($urandom_range(0, 5) == 0);
      advance();
    end

    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall sequencer for the five-stage MIPS core. It consumes the stage-tagged control signals emitted by the decode/pipeline controller plus the AXI-cache stall lines and the MEM-stage exception code. It produces the per-stage Stall_*/Flush_* enables that drive the pipeline registers, and the forwarding selects for the datapath. Sequential state covers the multi-cycle divider countdown and the deferral of exception redirects behind outstanding cache stalls.

## Interface
- DIV_CYCLES, 36: cycles a divide occupies EX (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rs_D, rt_D, rs_E, rt_E  in  5  source register numbers
- WriteReg_E, WriteReg_M, WriteReg_W  in  5  destination register numbers
- RegWrite_E, RegWrite_M, RegWrite_W  in  1  stage writes GPR
- MemtoReg_E, MemtoReg_M  in  3  nonzero = load in that stage
- Branch1_D  in  1  beq/bne in ID (uses rs and rt)
- Branch2_D  in  1  single-operand branch in ID (uses rs)
- JumpJr_D  in  1  jr/jalr in ID (uses rs)
- div_start_E  in  1  divide instruction in EX
- inst_stall_F, data_stall_M  in  1  I-/D-cache busy
- except_type_M  in  32  nonzero = exception on the MEM instruction
- Stall_F, Stall_D, Stall_E, Stall_M, Stall_W  out  1  hold stage register
- Flush_D, Flush_E, Flush_M, Flush_W  out  1  clear stage register (bubble)
- ForwardA_D, ForwardB_D  out  1  branch operand from MEM result
- ForwardA_E, ForwardB_E  out  2  00 regfile, 10 MEM result, 01 WB result
- exc_redirect  out  1  one-cycle pulse: load exception vector into PC
- div_busy  out  1  divider countdown active

## Operation
- State: FSM {RUN, PEND} plus a divider counter cnt (width clog2(DIV_CYCLES+1)).
- freeze = inst_stall_F | data_stall_M.
- Forwarding (combinational, no state):
  - A register number matches only if it is nonzero.
  - ForwardX_E = 10 if RegWrite_M & WriteReg_M==src. Else 01 if RegWrite_W & WriteReg_W==src. Else 00. MEM wins over WB.
  - ForwardX_D = RegWrite_M & WriteReg_M==src.
- lwstall = RegWrite_E & MemtoReg_E≠0 & WriteReg_E∈{rs_D,rt_D}.
- brstall covers two cases, using rs for Branch1/Branch2/JumpJr and rt only for Branch1:
  - RegWrite_E & WriteReg_E==operand, or
  - MemtoReg_M≠0 & WriteReg_M==operand.
- div_stall = div_start_E & cnt≠1.
- Divider counter:
  - cnt==0 & div_start_E & no flush → cnt←DIV_CYCLES.
  - cnt>1 → cnt−1.
  - cnt==1 & ~freeze → 0.
  - cnt==1 & freeze → stays at 1, so the divide cannot complete while the pipe is frozen.
  - div_busy = cnt≠0.
- exc = except_type_M≠0.
- Output priority (highest first). Any signal not set by the winning case is 0.
  1. rst: Flush_D/E/M/W=1, all stalls 0, exc_redirect 0.
  2. freeze: all five stalls=1, flushes 0. If exc, or if state is PEND, go to / stay in PEND.
  3. exc or PEND (not frozen): Flush_D/E/M/W=1, exc_redirect=1, cnt←0, state→RUN.
  4. div_stall: Stall_F/D/E=1, Flush_M=1.
  5. lwstall|brstall: Stall_F/D=1, Flush_E=1.
  6. Otherwise: all 0.

## Timing
- Reset: state RUN, cnt 0, div_busy 0. Outputs follow rule 1 while rst=1.
- Forwarding and stall outputs are combinational from inputs and current state. There is zero-cycle latency.
- Divide entering EX at cycle t with no freeze:
  - Stall_E is high for cycles t..t+DIV_CYCLES−1.
  - Released at t+DIV_CYCLES.
  - div_busy is high for cycles t+1..t+DIV_CYCLES.
- A back-to-back divide restarts the count on the cycle after release.
- Exception without freeze: exc_redirect and flushes occur the same cycle exc is seen.
- Exception during freeze: exc_redirect is deferred to the first non-frozen cycle. Exactly one pulse is issued, even if exc persists during freeze.
- Flush cancels an in-flight divide. cnt is 0 on the next cycle.
- rst mid-divide or in PEND: cnt=0 and state RUN on the next cycle; no redirect is issued.

## Test plan
- Forwarding: RegWrite_M=1, WriteReg_M=5; RegWrite_W=1, WriteReg_W=5; rs_E=5 → ForwardA_E=10. With RegWrite_M=0 → 01. With rs_E=0 → 00.
- Load-use: MemtoReg_E=1, RegWrite_E=1, WriteReg_E=8, rt_D=8 → Stall_F=Stall_D=Flush_E=1, Stall_E=0. Same with WriteReg_E=0 → all 0.
- Branch: Branch2_D=1, rs_D=3, MemtoReg_M=1, WriteReg_M=3 → Stall_F/D=1, Flush_E=1. With MemtoReg_M=0 and RegWrite_M=1 → no stall and ForwardA_D=1.
- Divide, DIV_CYCLES=4: div_start_E held high → Stall_E=1 for exactly 4 cycles with Flush_M=1, div_busy high for cycles 2–5. Inject inst_stall_F when cnt=1 → cnt holds at 1 and releases on the first cycle after the stall drops.
- Deferred exception: data_stall_M=1 for 3 cycles with except_type_M=0x10 → all stalls 1 and exc_redirect 0 during those cycles. The cycle after the stall drops gives exc_redirect=1 and Flush_D..W=1 for one cycle, then state RUN.
- Reset: assert rst during a divide with state PEND → next cycle div_busy=0, no exc_redirect, flushes 1 while rst high.
